// File: rtl/alu_cmd_issuer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// alu_cmd_issuer
//
// Initiator-side controller for the registered 8-bit ALU. Accepts one
// operation over a valid/ready command port, drives the ALU operand/select
// inputs, captures the registered ALU result two cycles later and returns it
// with the command tag, an error code and a carry flag over a valid/ready
// response port. Exactly one operation is outstanding at any time.
//
// Ports:
//   clock       rising-edge clock, shared with the ALU
//   reset_n     synchronous active-low reset
//   cmd_valid   command request
//   cmd_ready   issuer can accept a command (IDLE only)
//   cmd_op      0000 add, 0001 sub, 0010 mul, 0011 div, others illegal
//   cmd_a/b     operands
//   cmd_tag     opaque tag, returned unchanged on rsp_tag
//   alu_a/b     ALU operand inputs, held between accepts
//   alu_sel     ALU select input, held between accepts
//   alu_out     ALU registered result
//   alu_carry   ALU registered carry (always the carry of A+B)
//   rsp_valid   response available
//   rsp_ready   response consumer ready
//   rsp_data    result (0 on error)
//   rsp_carry   carry, only ever set for add
//   rsp_err     00 ok, 01 illegal op, 10 divide by zero
//   rsp_tag     tag of the command
//   busy        high in any state other than IDLE
//   op_count    completed responses, wraps silently
// ----------------------------------------------------------------------------
module alu_cmd_issuer #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [7:0]       alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_carry,
  output logic [1:0]       rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [1:0] ERR_OK = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_DIV0 = 2'b10;

  // Error is decided at accept time from the command itself, so the ALU's
  // undefined output for illegal/div-by-zero cases never has to be inspected.
  function automatic logic [1:0] calc_err(input logic [3:0] op, input logic [7:0] b);
    logic [1:0] e;
    if (op > OP_DIV) begin
      e = ERR_ILLEGAL;
    end else if ((op == OP_DIV) && (b == 8'h00)) begin
      e = ERR_DIV0;
    end else begin
      e = ERR_OK;
    end
    return e;
  endfunction

  state_t             state_r;
  state_t             state_s;
  logic               accept_s;
  logic               handshake_s;

  logic               cmd_ready_r;
  logic               busy_r;
  logic [7:0]         alu_a_r;
  logic [7:0]         alu_b_r;
  logic [3:0]         alu_sel_r;
  logic [1:0]         err_r;
  logic [TAG_W-1:0]   tag_r;
  logic               rsp_valid_r;
  logic [7:0]         rsp_data_r;
  logic               rsp_carry_r;
  logic [1:0]         rsp_err_r;
  logic [TAG_W-1:0]   rsp_tag_r;
  logic [CNT_W-1:0]   op_count_r;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and the accept/handshake strobes.
  always_comb begin
    state_s     = state_r;
    accept_s    = 1'b0;
    handshake_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          accept_s = 1'b1;
          state_s  = EXEC;
        end else begin
          state_s  = IDLE;
        end
      end
      // ALU inputs are stable; the ALU registers its result at this edge.
      EXEC: state_s = CAPT;
      // alu_out/alu_carry are valid this cycle and get captured.
      CAPT: state_s = RESP;
      RESP: begin
        if (rsp_valid_r && rsp_ready) begin
          handshake_s = 1'b1;
          state_s     = IDLE;
        end else begin
          state_s     = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: operand issue, result capture, response holding and counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cmd_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      alu_a_r     <= 8'h00;
      alu_b_r     <= 8'h00;
      alu_sel_r   <= 4'h0;
      err_r       <= ERR_OK;
      tag_r       <= '0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 8'h00;
      rsp_carry_r <= 1'b0;
      rsp_err_r   <= ERR_OK;
      rsp_tag_r   <= '0;
      op_count_r  <= '0;
    end else begin
      // Registered from next state so ready/busy line up with the state.
      cmd_ready_r <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);

      if (accept_s) begin
        alu_a_r   <= cmd_a;
        alu_b_r   <= cmd_b;
        alu_sel_r <= cmd_op;
        err_r     <= calc_err(cmd_op, cmd_b);
        tag_r     <= cmd_tag;
      end

      if (state_r == CAPT) begin
        rsp_valid_r <= 1'b1;
        rsp_err_r   <= err_r;
        rsp_tag_r   <= tag_r;
        if (err_r == ERR_OK) begin
          rsp_data_r  <= alu_out;
          // The ALU carry is always that of A+B; only add may report it.
          rsp_carry_r <= (alu_sel_r == OP_ADD) ? alu_carry : 1'b0;
        end else begin
          rsp_data_r  <= 8'h00;
          rsp_carry_r <= 1'b0;
        end
      end

      if (handshake_s) begin
        rsp_valid_r <= 1'b0;
        op_count_r  <= op_count_r + CNT_W'(1);
      end
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign alu_sel   = alu_sel_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_carry = rsp_carry_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_tag   = rsp_tag_r;
  assign op_count  = op_count_r;

endmodule
